// File: rtl/axis_arb_pkg.sv
// Shared definitions for the AXI-Stream round-robin arbiter: the arbiter
// state encoding and a width helper used to size port-index fields.
package axis_arb_pkg;

    // Arbiter state: IDLE while choosing a source, BUSY while a packet streams.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    // Number of bits needed to index 'value' items, never less than one so a
    // two-port arbiter still gets a real index bit.
    function automatic int clog2_min1(input int value);
        int width;
        width = 1;
        for (int w = 1; w < 32; w++) begin
            if ((1 << w) < value) begin
                width = w + 1;
            end
        end
        return width;
    endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin pick: finds the first requester strictly after
// last_grant, wrapping around, so the port served most recently always has
// the lowest priority. Holds no state; the owner keeps last_grant.
module rr_priority_select #(
    parameter int NUM_PORTS = 4,
    parameter int IDX_WIDTH = 2
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_WIDTH-1:0] last_grant,
    output logic [IDX_WIDTH-1:0] winner,
    output logic                 any_req
);

    // Walk offsets from the farthest position back toward last_grant+1, so the
    // nearest requester after last_grant is the last one written and wins.
    always_comb begin
        int               candidate;
        logic [IDX_WIDTH-1:0] cand_idx;
        winner    = '0;
        any_req   = |req;
        candidate = 0;
        cand_idx  = '0;
        for (int offset = NUM_PORTS; offset >= 1; offset--) begin
            candidate = int'(last_grant) + offset;
            if (candidate >= NUM_PORTS) begin
                candidate = candidate - NUM_PORTS;
            end
            cand_idx = IDX_WIDTH'(candidate);
            if (req[cand_idx]) begin
                winner = cand_idx;
            end
        end
    end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-granular round-robin arbiter: several AXI-Stream sources share one
// registered AXI-Stream output. A granted source owns the output until its
// TLAST beat is taken; m_axis_id tells downstream which source each beat
// came from.
module axis_rr_arbiter
    import axis_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_PORTS  = 4,
    parameter int ID_WIDTH   = 2
) (
    input  logic                            axi_clk,
    input  logic                            axi_reset,
    input  logic [NUM_PORTS-1:0]            s_axis_valid,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_data,
    input  logic [NUM_PORTS-1:0]            s_axis_last,
    output logic [NUM_PORTS-1:0]            s_axis_ready,
    output logic                            m_axis_valid,
    output logic [DATA_WIDTH-1:0]           m_axis_data,
    output logic                            m_axis_last,
    output logic [ID_WIDTH-1:0]             m_axis_id,
    input  logic                            m_axis_ready
);

    // Internal port index width; m_axis_id is that index fitted to ID_WIDTH.
    localparam int IDX_W  = clog2_min1(NUM_PORTS);
    localparam int COPY_W = (ID_WIDTH < IDX_W) ? ID_WIDTH : IDX_W;
    localparam logic [IDX_W-1:0] LAST_PORT = IDX_W'(NUM_PORTS - 1);

    arb_state_t            state;
    arb_state_t            state_next;
    logic [IDX_W-1:0]      grant;
    logic [IDX_W-1:0]      grant_next;
    logic [IDX_W-1:0]      last_grant;
    logic [IDX_W-1:0]      last_grant_next;
    logic [IDX_W-1:0]      rr_winner;
    logic                  rr_any_req;
    logic                  out_free;
    logic                  beat_accept;
    logic                  sel_valid;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [ID_WIDTH-1:0]   grant_id;

    rr_priority_select #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_WIDTH (IDX_W)
    ) u_rr_select (
        .req        (s_axis_valid),
        .last_grant (last_grant),
        .winner     (rr_winner),
        .any_req    (rr_any_req)
    );

    // The output stage can take a new beat when empty or draining this cycle.
    assign out_free = ~m_axis_valid | m_axis_ready;

    // Route the granted source's valid, data and last toward the output stage.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (grant == IDX_W'(p)) begin
                sel_valid = s_axis_valid[p];
                sel_last  = s_axis_last[p];
                sel_data  = s_axis_data[p*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Only the granted source sees ready, and only while the output has room;
    // every source is held off while the arbiter is choosing.
    always_comb begin
        s_axis_ready = '0;
        if (state == ST_BUSY) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (grant == IDX_W'(p)) begin
                    s_axis_ready[p] = out_free;
                end
            end
        end
    end

    assign beat_accept = (state == ST_BUSY) & sel_valid & out_free;

    // Next-state logic: pick a winner from IDLE, release on the TLAST accept.
    // Gaps in the granted source's valid simply keep the grant.
    always_comb begin
        state_next      = state;
        grant_next      = grant;
        last_grant_next = last_grant;
        case (state)
            ST_IDLE: begin
                if (rr_any_req) begin
                    grant_next = rr_winner;
                    state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (beat_accept && sel_last) begin
                    last_grant_next = grant;
                    state_next      = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Arbiter state registers; reset leaves port 0 with first priority and
    // abandons any packet in flight.
    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            state      <= ST_IDLE;
            grant      <= '0;
            last_grant <= LAST_PORT;
        end else begin
            state      <= state_next;
            grant      <= grant_next;
            last_grant <= last_grant_next;
        end
    end

    // Zero-extend or truncate the grant index into the ID sideband width.
    always_comb begin
        grant_id = '0;
        for (int b = 0; b < COPY_W; b++) begin
            grant_id[b] = grant[b];
        end
    end

    // Output register: load on accept, drop valid once drained with nothing
    // new, otherwise hold so data and last stay stable under backpressure.
    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            m_axis_valid <= 1'b0;
            m_axis_data  <= '0;
            m_axis_last  <= 1'b0;
            m_axis_id    <= '0;
        end else if (beat_accept) begin
            m_axis_valid <= 1'b1;
            m_axis_data  <= sel_data;
            m_axis_last  <= sel_last;
            m_axis_id    <= grant_id;
        end else if (m_axis_ready) begin
            m_axis_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed bench for axis_rr_arbiter: per-port beat queues feed the slave
// inputs, every output transfer is logged, and each test task compares the
// log and sampled outputs against hand-computed expectations.
module tb_axis_rr_arbiter;

    localparam int DW = 32;
    localparam int NP = 4;
    localparam int IW = 2;

    logic              axi_clk = 1'b0;
    logic              axi_reset = 1'b0;
    logic [NP-1:0]     s_axis_valid;
    logic [NP*DW-1:0]  s_axis_data;
    logic [NP-1:0]     s_axis_last;
    logic [NP-1:0]     s_axis_ready;
    logic              m_axis_valid;
    logic [DW-1:0]     m_axis_data;
    logic              m_axis_last;
    logic [IW-1:0]     m_axis_id;
    logic              m_axis_ready;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic          gap;
    } beat_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        logic [IW-1:0] id;
        int            cyc;
    } out_t;

    beat_t         src_q [NP][$];
    beat_t         exp_q [NP][$];
    out_t          out_log [$];
    logic [NP-1:0] acc;
    logic [NP-1:0] shown_gap;
    int            cyc = 0;
    int            errors = 0;
    int            checks = 0;
    bit            rdy_random = 1'b0;
    logic          rdy_fixed = 1'b1;

    axis_rr_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_PORTS  (NP),
        .ID_WIDTH   (IW)
    ) dut (
        .axi_clk      (axi_clk),
        .axi_reset    (axi_reset),
        .s_axis_valid (s_axis_valid),
        .s_axis_data  (s_axis_data),
        .s_axis_last  (s_axis_last),
        .s_axis_ready (s_axis_ready),
        .m_axis_valid (m_axis_valid),
        .m_axis_data  (m_axis_data),
        .m_axis_last  (m_axis_last),
        .m_axis_id    (m_axis_id),
        .m_axis_ready (m_axis_ready)
    );

    always #5 axi_clk = ~axi_clk;

    // Source/sink engine: drive queue heads at the falling edge, sample the
    // handshakes one time unit before the rising edge.
    initial begin
        out_t entry;
        s_axis_valid = '0;
        s_axis_last  = '0;
        s_axis_data  = '0;
        m_axis_ready = 1'b1;
        acc          = '0;
        shown_gap    = '0;
        forever begin
            @(negedge axi_clk);
            cyc++;
            for (int p = 0; p < NP; p++) begin
                if ((acc[p] || shown_gap[p]) && src_q[p].size() > 0) begin
                    void'(src_q[p].pop_front());
                end
                if (src_q[p].size() > 0) begin
                    s_axis_valid[p]         = ~src_q[p][0].gap;
                    s_axis_last[p]          = src_q[p][0].last;
                    s_axis_data[p*DW +: DW] = src_q[p][0].data;
                    shown_gap[p]            = src_q[p][0].gap;
                end else begin
                    s_axis_valid[p] = 1'b0;
                    s_axis_last[p]  = 1'b0;
                    shown_gap[p]    = 1'b0;
                end
            end
            m_axis_ready = rdy_random ? ($urandom_range(0, 3) != 0) : rdy_fixed;
            #4;
            acc = s_axis_valid & s_axis_ready;
            if (m_axis_valid === 1'b1 && m_axis_ready === 1'b1) begin
                entry.data = m_axis_data;
                entry.last = m_axis_last;
                entry.id   = m_axis_id;
                entry.cyc  = cyc;
                out_log.push_back(entry);
            end
        end
    end

    task automatic push_beat(input int p, input logic [DW-1:0] d, input logic last, input logic gap);
        beat_t bt;
        bt.data = d;
        bt.last = last;
        bt.gap  = gap;
        src_q[p].push_back(bt);
    endtask

    task automatic flush_bench();
        for (int p = 0; p < NP; p++) begin
            src_q[p].delete();
            exp_q[p].delete();
        end
        out_log.delete();
        s_axis_valid = '0;
        s_axis_last  = '0;
        acc          = '0;
        shown_gap    = '0;
    endtask

    function automatic bit all_empty();
        bit e;
        e = 1'b1;
        for (int p = 0; p < NP; p++) begin
            if (src_q[p].size() != 0) e = 1'b0;
        end
        return e;
    endfunction

    task automatic tick();
        @(negedge axi_clk);
        #2;
    endtask

    task automatic do_reset();
        tick();
        flush_bench();
        rdy_random = 1'b0;
        rdy_fixed  = 1'b1;
        axi_reset  = 1'b1;
        tick();
        axi_reset  = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, input string name);
        int n;
        n = 0;
        while (!(all_empty() && m_axis_valid === 1'b0) && n < max_cyc) begin
            tick();
            n++;
        end
        checks++;
        if (n >= max_cyc) begin
            errors++;
            $display("[TB] FAIL %s_drain: still busy after %0d cycles, required idle", name, n);
        end
    endtask

    task automatic test_reset();
        int n;
        do_reset();
        checks++; if (m_axis_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid: got %b expected 0", m_axis_valid); end
        checks++; if (m_axis_last !== 1'b0) begin errors++; $display("[TB] FAIL rst_last: got %b expected 0", m_axis_last); end
        checks++; if (m_axis_data !== '0) begin errors++; $display("[TB] FAIL rst_data: got %h expected 0", m_axis_data); end
        checks++; if (m_axis_id !== '0) begin errors++; $display("[TB] FAIL rst_id: got %0d expected 0", m_axis_id); end
        checks++; if (s_axis_ready !== '0) begin errors++; $display("[TB] FAIL rst_sready: got %b expected 0000", s_axis_ready); end

        // Port 0 finishes a packet, then port 1 starts a 4-beat one.
        push_beat(0, 32'h0000_0A01, 1'b1, 1'b0);
        for (int b = 0; b < 4; b++) push_beat(1, 32'h0000_1B00 + 32'(b), (b == 3), 1'b0);
        n = 0;
        while (!(m_axis_valid === 1'b1 && m_axis_id === 2'd1) && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 20) begin errors++; $display("[TB] FAIL rst_midpkt_start: port 1 beat not seen after %0d cycles", n); end
        checks++;
        if (out_log.size() != 1 || out_log[0].data !== 32'h0000_0A01) begin
            errors++; $display("[TB] FAIL rst_first_pkt: log size %0d, required one beat 00000a01", out_log.size());
        end

        // Reset lands while port 1 is mid-packet.
        flush_bench();
        axi_reset = 1'b1;
        tick();
        axi_reset = 1'b0;
        checks++; if (m_axis_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_valid: got %b expected 0", m_axis_valid); end
        checks++; if (s_axis_ready !== '0) begin errors++; $display("[TB] FAIL rst_mid_sready: got %b expected 0000", s_axis_ready); end
        checks++; if (m_axis_id !== '0) begin errors++; $display("[TB] FAIL rst_mid_id: got %0d expected 0", m_axis_id); end
        checks++; if (m_axis_data !== '0) begin errors++; $display("[TB] FAIL rst_mid_data: got %h expected 0", m_axis_data); end

        // Port 0 must win again even though it was served last before reset.
        flush_bench();
        push_beat(1, 32'h0000_1C01, 1'b1, 1'b0);
        push_beat(0, 32'h0000_0C01, 1'b1, 1'b0);
        wait_done(50, "rst_resume");
        checks++;
        if (out_log.size() != 2) begin
            errors++; $display("[TB] FAIL rst_resume_count: got %0d beats expected 2", out_log.size());
        end else begin
            checks++; if (out_log[0].id !== 2'd0) begin errors++; $display("[TB] FAIL rst_resume_first_id: got %0d expected 0", out_log[0].id); end
            checks++; if (out_log[0].data !== 32'h0000_0C01) begin errors++; $display("[TB] FAIL rst_resume_first_data: got %h expected 00000c01", out_log[0].data); end
            checks++; if (out_log[1].id !== 2'd1) begin errors++; $display("[TB] FAIL rst_resume_second_id: got %0d expected 1", out_log[1].id); end
        end
    endtask

    task automatic test_round_robin();
        logic [DW-1:0] exp_d;
        int            exp_gap;
        do_reset();
        for (int p = 0; p < NP; p++) begin
            for (int b = 0; b < 2; b++) begin
                push_beat(p, 32'hA000_0000 + 32'(p * 256 + b), (b == 1), 1'b0);
            end
        end
        wait_done(100, "rr");
        checks++;
        if (out_log.size() != 8) begin
            errors++; $display("[TB] FAIL rr_count: got %0d beats expected 8", out_log.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                exp_d = 32'hA000_0000 + 32'((k / 2) * 256 + (k % 2));
                checks++; if (out_log[k].id !== IW'(k / 2)) begin errors++; $display("[TB] FAIL rr_id[%0d]: got %0d expected %0d", k, out_log[k].id, k / 2); end
                checks++; if (out_log[k].data !== exp_d) begin errors++; $display("[TB] FAIL rr_data[%0d]: got %h expected %h", k, out_log[k].data, exp_d); end
                checks++; if (out_log[k].last !== 1'((k % 2) == 1)) begin errors++; $display("[TB] FAIL rr_last[%0d]: got %b expected %b", k, out_log[k].last, (k % 2) == 1); end
                if (k > 0) begin
                    exp_gap = (k % 2 == 1) ? 1 : 2;
                    checks++;
                    if (out_log[k].cyc - out_log[k-1].cyc != exp_gap) begin
                        errors++; $display("[TB] FAIL rr_spacing[%0d]: got %0d cycles expected %0d", k, out_log[k].cyc - out_log[k-1].cyc, exp_gap);
                    end
                end
            end
        end
    endtask

    task automatic test_gap_lock();
        logic [IW-1:0] exp_id   [4];
        logic [DW-1:0] exp_data [4];
        logic          exp_last [4];
        exp_id   = '{2'd2, 2'd2, 2'd2, 2'd0};
        exp_data = '{32'h2000_0001, 32'h2000_0002, 32'h2000_0003, 32'h0000_0F01};
        exp_last = '{1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        push_beat(2, 32'h2000_0001, 1'b0, 1'b0);
        push_beat(2, 32'h0, 1'b0, 1'b1);
        push_beat(2, 32'h0, 1'b0, 1'b1);
        push_beat(2, 32'h2000_0002, 1'b0, 1'b0);
        push_beat(2, 32'h2000_0003, 1'b1, 1'b0);
        tick();
        tick();
        push_beat(0, 32'h0000_0F01, 1'b1, 1'b0);
        wait_done(100, "gap");
        checks++;
        if (out_log.size() != 4) begin
            errors++; $display("[TB] FAIL gap_count: got %0d beats expected 4", out_log.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++; if (out_log[k].id !== exp_id[k]) begin errors++; $display("[TB] FAIL gap_id[%0d]: got %0d expected %0d", k, out_log[k].id, exp_id[k]); end
                checks++; if (out_log[k].data !== exp_data[k]) begin errors++; $display("[TB] FAIL gap_data[%0d]: got %h expected %h", k, out_log[k].data, exp_data[k]); end
                checks++; if (out_log[k].last !== exp_last[k]) begin errors++; $display("[TB] FAIL gap_last[%0d]: got %b expected %b", k, out_log[k].last, exp_last[k]); end
            end
            checks++;
            if (out_log[1].cyc - out_log[0].cyc != 3) begin
                errors++; $display("[TB] FAIL gap_spacing: got %0d cycles expected 3", out_log[1].cyc - out_log[0].cyc);
            end
        end
    endtask

    task automatic test_stall();
        int n;
        do_reset();
        rdy_fixed = 1'b0;
        push_beat(1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        push_beat(1, 32'h1234_5678, 1'b1, 1'b0);
        n = 0;
        while (m_axis_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 20) begin errors++; $display("[TB] FAIL stall_start: no output valid after %0d cycles", n); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (m_axis_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_valid[%0d]: got %b expected 1", i, m_axis_valid); end
            checks++; if (m_axis_data !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL stall_data[%0d]: got %h expected deadbeef", i, m_axis_data); end
            checks++; if (m_axis_last !== 1'b0) begin errors++; $display("[TB] FAIL stall_last[%0d]: got %b expected 0", i, m_axis_last); end
            checks++; if (m_axis_id !== 2'd1) begin errors++; $display("[TB] FAIL stall_id[%0d]: got %0d expected 1", i, m_axis_id); end
            checks++; if (s_axis_ready !== '0) begin errors++; $display("[TB] FAIL stall_sready[%0d]: got %b expected 0000", i, s_axis_ready); end
            tick();
        end
        rdy_fixed = 1'b1;
        wait_done(50, "stall");
        checks++;
        if (out_log.size() != 2) begin
            errors++; $display("[TB] FAIL stall_count: got %0d beats expected 2", out_log.size());
        end else begin
            checks++; if (out_log[0].data !== 32'hDEAD_BEEF || out_log[0].last !== 1'b0) begin errors++; $display("[TB] FAIL stall_beat0: got %h/%b expected deadbeef/0", out_log[0].data, out_log[0].last); end
            checks++; if (out_log[1].data !== 32'h1234_5678 || out_log[1].last !== 1'b1) begin errors++; $display("[TB] FAIL stall_beat1: got %h/%b expected 12345678/1", out_log[1].data, out_log[1].last); end
        end
    endtask

    task automatic test_fairness();
        logic [IW-1:0] exp_id;
        logic [DW-1:0] exp_d;
        do_reset();
        for (int k = 0; k < 6; k++) push_beat(3, 32'h3000_0000 + 32'(k), 1'b1, 1'b0);
        tick();
        tick();
        push_beat(1, 32'h1000_00AA, 1'b1, 1'b0);
        wait_done(100, "fair");
        checks++;
        if (out_log.size() != 7) begin
            errors++; $display("[TB] FAIL fair_count: got %0d beats expected 7", out_log.size());
        end else begin
            for (int k = 0; k < 7; k++) begin
                exp_id = (k == 1) ? 2'd1 : 2'd3;
                exp_d  = (k == 0) ? 32'h3000_0000 : (k == 1) ? 32'h1000_00AA : 32'h3000_0000 + 32'(k - 1);
                checks++; if (out_log[k].id !== exp_id) begin errors++; $display("[TB] FAIL fair_id[%0d]: got %0d expected %0d", k, out_log[k].id, exp_id); end
                checks++; if (out_log[k].data !== exp_d) begin errors++; $display("[TB] FAIL fair_data[%0d]: got %h expected %h", k, out_log[k].data, exp_d); end
            end
        end
    endtask

    task automatic test_scoreboard();
        int            p;
        int            len;
        logic [DW-1:0] d;
        beat_t         bt;
        beat_t         ex;
        bit            in_pkt;
        logic [IW-1:0] cur;
        do_reset();
        for (int n = 0; n < 1000; n++) begin
            p   = int'($urandom_range(0, NP - 1));
            len = int'($urandom_range(1, 8));
            for (int b = 0; b < len; b++) begin
                if ($urandom_range(0, 3) == 0) push_beat(p, 32'h0, 1'b0, 1'b1);
                d = $urandom;
                push_beat(p, d, (b == len - 1), 1'b0);
                bt.data = d;
                bt.last = (b == len - 1);
                bt.gap  = 1'b0;
                exp_q[p].push_back(bt);
            end
        end
        rdy_random = 1'b1;
        wait_done(60000, "sb");
        rdy_random = 1'b0;
        in_pkt = 1'b0;
        cur    = '0;
        foreach (out_log[i]) begin
            p = int'(out_log[i].id);
            checks++;
            if (in_pkt && out_log[i].id !== cur) begin
                errors++; $display("[TB] FAIL sb_interleave[%0d]: got id %0d expected %0d", i, out_log[i].id, cur);
            end
            checks++;
            if (exp_q[p].size() == 0) begin
                errors++; $display("[TB] FAIL sb_extra[%0d]: port %0d beat %h with nothing expected", i, p, out_log[i].data);
            end else begin
                ex = exp_q[p].pop_front();
                if (out_log[i].data !== ex.data || out_log[i].last !== ex.last) begin
                    errors++; $display("[TB] FAIL sb_beat[%0d]: port %0d got %h/%b expected %h/%b", i, p, out_log[i].data, out_log[i].last, ex.data, ex.last);
                end
            end
            in_pkt = ~out_log[i].last;
            cur    = out_log[i].id;
        end
        for (int q = 0; q < NP; q++) begin
            checks++;
            if (exp_q[q].size() != 0) begin
                errors++; $display("[TB] FAIL sb_missing[%0d]: %0d beats never appeared, expected 0", q, exp_q[q].size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_gap_lock();
        test_stall();
        test_fairness();
        test_scoreboard();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
